// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge header bus arbiter.
// Build option: CART_DATA_SYNC_EN (see cart_bus_arbiter.sv).
package cart_bus_pkg;

  localparam int CART_AW = 14;

  localparam logic [1:0] S4_TAG = 2'b01;
  localparam logic [1:0] S5_TAG = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/cart_window_decode.sv
// Maps a 16-bit core address onto the S4/S5 cartridge windows.
module cart_window_decode
  import cart_bus_pkg::*;
(
  input  logic [15:0]        addr_i,
  input  logic               rd4_en_i,
  input  logic               rd5_en_i,
  output logic               hit_o,
  output logic               sel_s4_o,
  output logic               sel_s5_o,
  output logic [CART_AW-1:0] cart_addr_o
);

  logic [1:0] tag;

  assign tag         = addr_i[15:14];
  assign sel_s4_o    = (tag == S4_TAG) && rd4_en_i;
  assign sel_s5_o    = (tag == S5_TAG) && rd5_en_i;
  assign hit_o       = sel_s4_o || sel_s5_o;
  assign cart_addr_o = addr_i[CART_AW-1:0];

endmodule

// File: rtl/cart_bus_arbiter.sv
// Two-requester round-robin read arbiter for the HDR1 cartridge bus.
// Define CART_DATA_SYNC_EN to pass cart_data through a 2-flop synchronizer.
module cart_bus_arbiter #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [7:0]  MISS_DATA   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  input  logic        rd4_en,
  input  logic        rd5_en,
  output logic [13:0] cart_addr,
  output logic        cart_s4,
  output logic        cart_s5,
  input  logic [7:0]  cart_data,
  output logic        busy,
  output logic        grant
);
  import cart_bus_pkg::*;

`ifdef CART_DATA_SYNC_EN
  localparam int WAIT_TOTAL = WAIT_CYCLES + 2;
`else
  localparam int WAIT_TOTAL = WAIT_CYCLES;
`endif
  localparam int CNT_W = $clog2(WAIT_TOTAL + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [CART_AW-1:0] cart_addr_q, cart_addr_d;
  logic               s4_q, s4_d;
  logic               s5_q, s5_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [7:0]         samp_data;

  logic               win;
  logic [15:0]        win_addr;
  logic               dec_hit, dec_s4, dec_s5;
  logic [CART_AW-1:0] dec_addr;

  // Contention goes to whoever was not served last; a lone request always wins.
  assign win      = (req0 && req1) ? !last_q : req1;
  assign win_addr = win ? addr1 : addr0;

  cart_window_decode u_dec (
    .addr_i      (win_addr),
    .rd4_en_i    (rd4_en),
    .rd5_en_i    (rd5_en),
    .hit_o       (dec_hit),
    .sel_s4_o    (dec_s4),
    .sel_s5_o    (dec_s5),
    .cart_addr_o (dec_addr)
  );

`ifdef CART_DATA_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cart_data;
      sync2_q <= sync1_q;
    end
  end

  assign samp_data = sync2_q;
`else
  assign samp_data = cart_data;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cart_addr_d = cart_addr_q;
    s4_d        = s4_q;
    s5_d        = s5_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = win;
          last_d  = win;
          if (dec_hit) begin
            state_d     = SETUP;
            cart_addr_d = dec_addr;
            s4_d        = dec_s4;
            s5_d        = dec_s5;
          end else begin
            // Unpopulated window: answer immediately, never touch the bus.
            state_d = ACK;
            rdata_d = MISS_DATA;
          end
        end
      end
      SETUP: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(WAIT_TOTAL - 1);
      end
      WAIT: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        state_d = ACK;
        rdata_d = samp_data;
        s4_d    = 1'b0;
        s5_d    = 1'b0;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cart_addr_q <= '0;
      s4_q        <= 1'b0;
      s5_q        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cart_addr_q <= cart_addr_d;
      s4_q        <= s4_d;
      s5_q        <= s5_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack0      = (state_q == ACK) && !grant_q;
  assign ack1      = (state_q == ACK) &&  grant_q;
  assign rdata     = rdata_q;
  assign cart_addr = cart_addr_q;
  assign cart_s4   = s4_q;
  assign cart_s5   = s5_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Self-checking bench for cart_bus_arbiter against a transaction-level model.
module tb_cart_bus_arbiter;

  localparam int WAIT_CYCLES = 4;
`ifdef CART_DATA_SYNC_EN
  localparam int HIT_LAT = WAIT_CYCLES + 5;
`else
  localparam int HIT_LAT = WAIT_CYCLES + 3;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, rd4_en = 1'b0, rd5_en = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic        ack0, ack1, cart_s4, cart_s5, busy, grant;
  logic [7:0]  rdata, cart_data;
  logic [13:0] cart_addr;
  logic        fix_en = 1'b0;
  logic [7:0]  fix_val = '0;
  int          n_pass = 0, n_total = 0;
  logic        m_last = 1'b1;

  always #5 clk = ~clk;

  cart_bus_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .MISS_DATA(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .rd4_en(rd4_en), .rd5_en(rd5_en),
    .cart_addr(cart_addr), .cart_s4(cart_s4), .cart_s5(cart_s5), .cart_data(cart_data),
    .busy(busy), .grant(grant)
  );

  // Cartridge memory model: contents depend on window and address.
  always_comb begin
    cart_data = cart_addr[7:0] ^ {2'b00, cart_addr[13:8]} ^ (cart_s5 ? 8'h3C : 8'hA5);
    if (fix_en) cart_data = fix_val;
  end

  function automatic logic is_hit(input logic [15:0] a, input logic e4, input logic e5);
    return (a >= 16'h4000 && a < 16'h8000 && e4) || (a >= 16'h8000 && a < 16'hC000 && e5);
  endfunction

  function automatic logic [7:0] exp_data(input logic [15:0] a, input logic e4, input logic e5);
    logic [7:0] v;
    if (!is_hit(a, e4, e5)) return 8'hFF;
    if (fix_en) return fix_val;
    v = a[7:0] ^ {2'b00, a[13:8]} ^ ((a >= 16'h8000) ? 8'h3C : 8'hA5);
    return v;
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic e4, input logic e5);
    return is_hit(a, e4, e5) ? HIT_LAT : 1;
  endfunction

  // Observer only: runs cycles until an ack, collecting bus activity.
  task automatic wait_ack(output int lat, output logic id, output logic gr, output logic [7:0] rd,
                          output int n4, output int n5, output int nbad, output logic [13:0] saddr);
    lat = -1; id = 1'b0; gr = 1'b0; rd = '0; n4 = 0; n5 = 0; nbad = 0; saddr = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (cart_s4) n4++;
      if (cart_s5) n5++;
      if (cart_s4 && cart_s5) nbad++;
      if (ack0 && ack1) nbad++;
      if ((cart_s4 || cart_s5) && (n4 + n5) > 1 && cart_addr !== saddr) nbad++;
      if (cart_s4 || cart_s5) saddr = cart_addr;
      if (ack0 || ack1) begin
        lat = c; id = ack1; gr = grant; rd = rdata;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; m_last = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if ({cart_addr, cart_s4, cart_s5} !== 16'h0) $display("FAIL reset_bus got %h exp 0", {cart_addr, cart_s4, cart_s5}); else n_pass++;
    n_total++; if ({ack0, ack1, rdata, busy, grant} !== 12'h0) $display("FAIL reset_ctl got %h exp 0", {ack0, ack1, rdata, busy, grant}); else n_pass++;
  endtask

  task automatic test_s4_read();
    int lat, n4, n5, nb; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    fix_en = 1'b1; fix_val = 8'hA5; rd4_en = 1'b1; rd5_en = 1'b0;
    addr0 = 16'h4123; req0 = 1'b1;
    wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
    req0 = 1'b0; m_last = 1'b0;
    n_total++; if (lat !== HIT_LAT) $display("FAIL s4_lat got %0d exp %0d", lat, HIT_LAT); else n_pass++;
    n_total++; if ({id, gr} !== 2'b00) $display("FAIL s4_id got %b exp 00", {id, gr}); else n_pass++;
    n_total++; if (rd !== 8'hA5) $display("FAIL s4_rdata got %h exp a5", rd); else n_pass++;
    n_total++; if (n4 !== HIT_LAT - 1 || n5 !== 0) $display("FAIL s4_sel got s4=%0d s5=%0d exp s4=%0d s5=0", n4, n5, HIT_LAT - 1); else n_pass++;
    n_total++; if (sa !== 14'h0123 || nb !== 0) $display("FAIL s4_addr got %h bad=%0d exp 0123 bad=0", sa, nb); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL s4_idle busy got %b exp 0", busy); else n_pass++;
    fix_en = 1'b0;
  endtask

  task automatic test_s5_read();
    int lat, n4, n5, nb; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    fix_en = 1'b1; fix_val = 8'h3C; rd4_en = 1'b0; rd5_en = 1'b1;
    addr1 = 16'hBFFF; req1 = 1'b1;
    wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
    req1 = 1'b0; m_last = 1'b1;
    n_total++; if (lat !== HIT_LAT || {id, gr} !== 2'b11) $display("FAIL s5_ack got lat=%0d id=%b exp lat=%0d id=11", lat, {id, gr}, HIT_LAT); else n_pass++;
    n_total++; if (rd !== 8'h3C) $display("FAIL s5_rdata got %h exp 3c", rd); else n_pass++;
    n_total++; if (n5 !== HIT_LAT - 1 || n4 !== 0 || sa !== 14'h3FFF || nb !== 0) $display("FAIL s5_bus got s4=%0d s5=%0d a=%h bad=%0d exp s5=%0d a=3fff", n4, n5, sa, nb, HIT_LAT - 1); else n_pass++;
    @(posedge clk); #1;
    fix_en = 1'b0;
  endtask

  task automatic test_miss();
    int lat, n4, n5, nb; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    logic [15:0] ma [2];
    ma[0] = 16'h9000; ma[1] = 16'hC000;
    rd4_en = 1'b1; rd5_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) rd5_en = 1'b1;
      addr0 = ma[k]; req0 = 1'b1;
      wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
      req0 = 1'b0; m_last = 1'b0;
      n_total++; if (lat !== 1 || id !== 1'b0) $display("FAIL miss%0d_ack got lat=%0d id=%b exp lat=1 id=0", k, lat, id); else n_pass++;
      n_total++; if (rd !== 8'hFF) $display("FAIL miss%0d_rdata got %h exp ff", k, rd); else n_pass++;
      n_total++; if (n4 + n5 + nb !== 0) $display("FAIL miss%0d_sel got s4=%0d s5=%0d bad=%0d exp none", k, n4, n5, nb); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int lat, n4, n5, nb; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    logic exp_id; logic [15:0] a;
    do_reset();
    rd4_en = 1'b1; rd5_en = 1'b1;
    addr0 = 16'($urandom); addr1 = 16'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    exp_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = exp_id ? addr1 : addr0;
      wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
      n_total++; if (id !== exp_id || gr !== exp_id) $display("FAIL rr%0d_id got %b/%b exp %b", k, id, gr, exp_id); else n_pass++;
      n_total++; if (rd !== exp_data(a, 1'b1, 1'b1)) $display("FAIL rr%0d_rdata got %h exp %h", k, rd, exp_data(a, 1'b1, 1'b1)); else n_pass++;
      n_total++; if (lat !== exp_lat(a, 1'b1, 1'b1) || nb !== 0) $display("FAIL rr%0d_lat got %0d bad=%0d exp %0d", k, lat, nb, exp_lat(a, 1'b1, 1'b1)); else n_pass++;
      if (exp_id) addr1 = 16'($urandom); else addr0 = 16'($urandom);
      exp_id = !exp_id;
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0; m_last = !exp_id;
    repeat (HIT_LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    int lat, n4, n5, nb; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    rd4_en = 1'b1; rd5_en = 1'b0; addr0 = 16'h4010; req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (cart_s4 !== 1'b1 || busy !== 1'b1) $display("FAIL rstw_pre got s4=%b busy=%b exp 1/1", cart_s4, busy); else n_pass++;
    rst_n = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({cart_s4, cart_s5, busy, ack0, ack1} !== 5'b0) $display("FAIL rstw_abort got %b exp 00000", {cart_s4, cart_s5, busy, ack0, ack1}); else n_pass++;
    n_total++; if (rdata !== 8'h00) $display("FAIL rstw_rdata got %h exp 00", rdata); else n_pass++;
    rst_n = 1'b1; m_last = 1'b1;
    addr0 = 16'h4ABC; req0 = 1'b1;
    wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
    req0 = 1'b0; m_last = 1'b0;
    n_total++; if (lat !== HIT_LAT || id !== 1'b0) $display("FAIL rstw_ack got lat=%0d id=%b exp lat=%0d id=0", lat, id, HIT_LAT); else n_pass++;
    n_total++; if (rd !== exp_data(16'h4ABC, 1'b1, 1'b0) || sa !== 14'h0ABC) $display("FAIL rstw_data got %h a=%h exp %h a=0abc", rd, sa, exp_data(16'h4ABC, 1'b1, 1'b0)); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, n4, n5, nb, e4, e5; logic id, gr; logic [7:0] rd; logic [13:0] sa;
    logic p0, p1, w, eh; logic [15:0] a;
    p0 = 1'b0; p1 = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; addr0 = 16'($urandom); end
      if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; addr1 = 16'($urandom); end
      if (!p0 && !p1) begin p0 = 1'b1; addr0 = 16'($urandom); end
      rd4_en = 1'($urandom); rd5_en = 1'($urandom);
      req0 = p0; req1 = p1;
      w  = (p0 && p1) ? !m_last : p1;
      a  = w ? addr1 : addr0;
      eh = is_hit(a, rd4_en, rd5_en);
      e4 = (eh && a < 16'h8000) ? HIT_LAT - 1 : 0;
      e5 = (eh && a >= 16'h8000) ? HIT_LAT - 1 : 0;
      wait_ack(lat, id, gr, rd, n4, n5, nb, sa);
      n_total++; if (id !== w || gr !== w) $display("FAIL rnd%0d_id got %b/%b exp %b", it, id, gr, w); else n_pass++;
      n_total++; if (lat !== exp_lat(a, rd4_en, rd5_en)) $display("FAIL rnd%0d_lat got %0d exp %0d", it, lat, exp_lat(a, rd4_en, rd5_en)); else n_pass++;
      n_total++; if (rd !== exp_data(a, rd4_en, rd5_en)) $display("FAIL rnd%0d_rdata got %h exp %h (a=%h)", it, rd, exp_data(a, rd4_en, rd5_en), a); else n_pass++;
      n_total++; if (n4 !== e4 || n5 !== e5 || nb !== 0 || (eh && sa !== a[13:0])) $display("FAIL rnd%0d_bus got s4=%0d s5=%0d a=%h bad=%0d exp s4=%0d s5=%0d a=%h", it, n4, n5, sa, nb, e4, e5, a[13:0]); else n_pass++;
      m_last = w;
      if (w) p1 = 1'b0; else p0 = 1'b0;
      @(posedge clk); #1;
      n_total++; if (busy !== 1'b0) $display("FAIL rnd%0d_idle busy got %b exp 0", it, busy); else n_pass++;
      req0 = p0; req1 = p1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_s4_read();
    test_s5_read();
    test_miss();
    test_round_robin();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
